uart_fifo_hd_ctrl: RTL and testbench

Single-clock, parametrised successor to the UART FIFO front end. It sits between host logic and a byte-level UART core.
- Buffers TX and RX bytes in first-word-fall-through FIFOs and reports fill levels.
- Tags each RX entry with the core's error flag.
- Adds half-duplex (single-wire UPDI) support: line-turnaround guard time, echo suppression with mismatch/timeout detection, sticky overflow and echo-fault flags.

---
 rtl/uart_fifo_pkg.sv | 18 +
 rtl/sync_fwft_fifo.sv | 59 +++++
 rtl/uart_fifo_hd_ctrl.sv | 172 +++++++++++++++++
 tb/tb_uart_fifo_hd_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared types for the UART FIFO front ends: TX sequencer states and a
// helper that sizes saturating counters.
package uart_fifo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GUARD,
    LOAD,
    START,
    WAIT_ECHO
  } uart_fifo_hd_tx_state;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO: the head entry is always on
// rd_data while !empty, a write becomes visible on the following cycle.
module sync_fwft_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int LW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == LW'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign do_rd = rd_en && !empty && !flush;
  assign do_wr = wr_en && !flush && (!full || do_rd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !do_rd)      count <= count + LW'(1);
      else if (do_rd && !do_wr) count <= count - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_fifo_hd_ctrl.sv
// UART FIFO front end with half-duplex support: TX/RX FWFT buffering, line
// turnaround guard time, echo suppression and sticky fault flags.
module uart_fifo_hd_ctrl
  import uart_fifo_pkg::*;
#(
  parameter  int DATA_BITS    = 8,
  parameter  int FIFO_DEPTH   = 16,
  parameter  int GUARD_BITS   = 2,
  parameter  int ECHO_TIMEOUT = 24,
  localparam int LW           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hd_en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_wr_en,
  input  logic                 tx_flush,
  output logic                 tx_full,
  output logic [LW-1:0]        tx_level,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_err,
  input  logic                 rx_rd_en,
  output logic                 rx_empty,
  output logic [LW-1:0]        rx_level,
  output logic                 rx_overflow,
  output logic                 echo_fault,
  input  logic                 clr_flags,
  output logic                 busy,
  output logic [DATA_BITS-1:0] core_tx_data,
  output logic                 core_tx_start,
  input  logic                 core_tx_ready,
  input  logic [DATA_BITS-1:0] core_rx_data,
  input  logic                 core_rx_valid,
  input  logic                 core_rx_error,
  input  logic                 bit_tick,
  output uart_fifo_hd_tx_state state
);

  localparam int GW = cnt_width(GUARD_BITS);
  localparam int TW = cnt_width(ECHO_TIMEOUT);

  // Handshake: core_tx_start is raised in START while core_tx_ready=1 and
  // dropped once the core pulls core_tx_ready low after seeing it; that
  // falling edge (start was high the cycle before) is the acknowledge.

  uart_fifo_hd_tx_state state_q;
  uart_fifo_hd_tx_state next_state;
  uart_fifo_hd_tx_state idle_next;

  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_empty;
  logic                 tx_pop;
  logic [DATA_BITS:0]   rx_head;
  logic                 rx_full;
  logic                 rx_wr;

  logic [GW-1:0]        guard_cnt;
  logic                 guard_done;
  logic [TW-1:0]        to_cnt;
  logic                 echo_timeout;
  logic                 echo_check;
  logic                 echo_set;
  logic                 ovf_set;
  logic                 tx_ack;
  logic                 start_q;
  logic                 hd_mode;
  logic [DATA_BITS-1:0] exp_echo;

  sync_fwft_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_wr_en),
    .wr_data (tx_data),
    .rd_en   (tx_pop),
    .rd_data (tx_head),
    .flush   (tx_flush),
    .full    (tx_full),
    .empty   (tx_empty),
    .level   (tx_level)
  );

  sync_fwft_fifo #(.WIDTH(DATA_BITS + 1), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rx_wr),
    .wr_data ({core_rx_error, core_rx_data}),
    .rd_en   (rx_rd_en),
    .rd_data (rx_head),
    .flush   (1'b0),
    .full    (rx_full),
    .empty   (rx_empty),
    .level   (rx_level)
  );

  assign rx_data     = rx_head[DATA_BITS-1:0];
  assign rx_data_err = rx_head[DATA_BITS];
  assign state       = state_q;

  assign guard_done   = (guard_cnt == GW'(GUARD_BITS));
  assign tx_ack       = (state_q == START) && start_q && !core_tx_ready;
  assign echo_timeout = (state_q == WAIT_ECHO) && bit_tick && !core_rx_valid &&
                        (to_cnt == TW'(ECHO_TIMEOUT - 1));
  assign idle_next    = tx_empty ? IDLE : ((hd_mode && !guard_done) ? GUARD : LOAD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= next_state;
  end

  always_comb begin
    next_state = state_q;
    unique case (state_q)
      IDLE:  next_state = idle_next;
      GUARD: begin
        if (tx_empty)        next_state = IDLE;
        else if (guard_done) next_state = LOAD;
      end
      // A flush landing just before LOAD leaves nothing to send.
      LOAD:  next_state = tx_empty ? IDLE : START;
      START: begin
        if (tx_ack) next_state = hd_mode ? WAIT_ECHO : (tx_empty ? IDLE : LOAD);
      end
      WAIT_ECHO: begin
        if (core_rx_valid)     next_state = idle_next;
        else if (echo_timeout) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    core_tx_start = (state_q == START) && core_tx_ready;
    tx_pop        = (state_q == LOAD);
    echo_check    = (state_q == WAIT_ECHO) && core_rx_valid;
    busy          = (state_q != IDLE) || !core_tx_ready || !tx_empty;
    rx_wr         = core_rx_valid && !echo_check;
    ovf_set       = rx_wr && rx_full && !rx_rd_en;
    echo_set      = (echo_check && ((core_rx_data != exp_echo) || core_rx_error)) ||
                    echo_timeout;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_tx_data <= '0;
      exp_echo     <= '0;
      start_q      <= 1'b0;
      hd_mode      <= 1'b0;
      guard_cnt    <= GW'(GUARD_BITS);
      to_cnt       <= '0;
      rx_overflow  <= 1'b0;
      echo_fault   <= 1'b0;
    end else begin
      start_q <= core_tx_start;
      // Mode only changes between transfers so a frame never switches mid-flight.
      if (!busy) hd_mode <= hd_en;
      if ((state_q == LOAD) && !tx_empty) begin
        core_tx_data <= tx_head;
        exp_echo     <= tx_head;
      end
      if (rx_wr)                         guard_cnt <= '0;
      else if (bit_tick && !guard_done) guard_cnt <= guard_cnt + GW'(1);
      if (tx_ack)                        to_cnt <= '0;
      else if ((state_q == WAIT_ECHO) && bit_tick && !echo_timeout)
        to_cnt <= to_cnt + TW'(1);
      if (ovf_set)        rx_overflow <= 1'b1;
      else if (clr_flags) rx_overflow <= 1'b0;
      if (echo_set)       echo_fault <= 1'b1;
      else if (clr_flags) echo_fault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_fifo_hd_ctrl.sv
// Bench for uart_fifo_hd_ctrl: a UART core model driven from tasks, with
// scoreboard queues for transmitted and received bytes.
module tb_uart_fifo_hd_ctrl;
  import uart_fifo_pkg::*;

  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int LW         = $clog2(FIFO_DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 hd_en;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_wr_en;
  logic                 tx_flush;
  logic                 tx_full;
  logic [LW-1:0]        tx_level;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_data_err;
  logic                 rx_rd_en;
  logic                 rx_empty;
  logic [LW-1:0]        rx_level;
  logic                 rx_overflow;
  logic                 echo_fault;
  logic                 clr_flags;
  logic                 busy;
  logic [DATA_BITS-1:0] core_tx_data;
  logic                 core_tx_start;
  logic                 core_tx_ready;
  logic [DATA_BITS-1:0] core_rx_data;
  logic                 core_rx_valid;
  logic                 core_rx_error;
  logic                 bit_tick;
  uart_fifo_hd_tx_state state;

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_BITS-1:0] exp_tx_q[$];
  logic [DATA_BITS:0]   exp_rx_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  uart_fifo_hd_ctrl #(
    .DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH), .GUARD_BITS(2), .ECHO_TIMEOUT(24)
  ) dut (
    .clk(clk), .rst(rst), .hd_en(hd_en),
    .tx_data(tx_data), .tx_wr_en(tx_wr_en), .tx_flush(tx_flush),
    .tx_full(tx_full), .tx_level(tx_level),
    .rx_data(rx_data), .rx_data_err(rx_data_err), .rx_rd_en(rx_rd_en),
    .rx_empty(rx_empty), .rx_level(rx_level),
    .rx_overflow(rx_overflow), .echo_fault(echo_fault), .clr_flags(clr_flags),
    .busy(busy), .core_tx_data(core_tx_data), .core_tx_start(core_tx_start),
    .core_tx_ready(core_tx_ready), .core_rx_data(core_rx_data),
    .core_rx_valid(core_rx_valid), .core_rx_error(core_rx_error),
    .bit_tick(bit_tick), .state(state)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks (enter and leave on a negedge) ----------------
  task automatic push_tx(input logic [DATA_BITS-1:0] b);
    tx_data  = b;
    tx_wr_en = 1'b1;
    @(negedge clk);
    tx_wr_en = 1'b0;
    exp_tx_q.push_back(b);
  endtask

  task automatic rx_byte(input logic [DATA_BITS-1:0] d, input logic err, input bit store);
    core_rx_data  = d;
    core_rx_error = err;
    core_rx_valid = 1'b1;
    @(negedge clk);
    core_rx_valid = 1'b0;
    core_rx_error = 1'b0;
    if (store) exp_rx_q.push_back({err, d});
  endtask

  task automatic bit_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bit_tick = 1'b1;
      @(negedge clk);
      bit_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  // Core model: wait for start, latch it on a posedge, acknowledge, stay busy.
  task automatic serve_tx();
    int waited = 0;
    logic [DATA_BITS-1:0] exp_b;
    while (core_tx_start !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (core_tx_start !== 1'b1) begin
      check("tx_start_timeout", 0, 1);
      return;
    end
    check("tx_q_nonempty", 32'(exp_tx_q.size() != 0), 1);
    exp_b = (exp_tx_q.size() != 0) ? exp_tx_q.pop_front() : '0;
    check("core_tx_data", 32'(core_tx_data), 32'(exp_b));
    @(negedge clk);
    core_tx_ready = 1'b0;
    @(negedge clk);
    check("tx_start_dropped", 32'(core_tx_start), 0);
    repeat (3) @(negedge clk);
    core_tx_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic read_rx(input string tag);
    logic [DATA_BITS:0] e;
    check({tag, "_avail"}, 32'(rx_empty), 0);
    check({tag, "_q_nonempty"}, 32'(exp_rx_q.size() != 0), 1);
    e = (exp_rx_q.size() != 0) ? exp_rx_q.pop_front() : '0;
    check(tag, 32'({rx_data_err, rx_data}), 32'(e));
    rx_rd_en = 1'b1;
    @(negedge clk);
    rx_rd_en = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [DATA_BITS:0] head;
    int waited;
    rst = 1'b0; hd_en = 1'b0; tx_data = '0; tx_wr_en = 1'b0; tx_flush = 1'b0;
    rx_rd_en = 1'b0; clr_flags = 1'b0; core_tx_ready = 1'b1; core_rx_data = '0;
    core_rx_valid = 1'b0; core_rx_error = 1'b0; bit_tick = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tx_level", 32'(tx_level), 0);
    check("rst_rx_empty", 32'(rx_empty), 1);
    check("rst_tx_start", 32'(core_tx_start), 0);
    check("rst_flags", 32'({rx_overflow, echo_fault}), 0);
    check("rst_state", 32'(state), 32'(IDLE));
    rst = 1'b1;
    @(negedge clk);

    // Full duplex: three bytes back to back.
    push_tx(8'h55); push_tx(8'hA3); push_tx(8'h0F);
    check("fd_level", 32'(tx_level), 2);
    for (int i = 0; i < 3; i++) serve_tx();
    check("fd_busy_low", 32'(busy), 0);
    check("fd_rx_empty", 32'(rx_empty), 1);

    // Half duplex: good echo, then bad echo.
    hd_en = 1'b1;
    repeat (2) @(negedge clk);
    push_tx(8'h12);
    serve_tx();
    check("hd_wait_echo", 32'(state), 32'(WAIT_ECHO));
    rx_byte(8'h12, 1'b0, 1'b0);
    check("hd_good_state", 32'(state), 32'(IDLE));
    check("hd_good_fault", 32'(echo_fault), 0);
    check("hd_good_rx_empty", 32'(rx_empty), 1);
    push_tx(8'h12);
    serve_tx();
    rx_byte(8'h13, 1'b0, 1'b0);
    check("hd_bad_fault", 32'(echo_fault), 1);
    check("hd_bad_rx_empty", 32'(rx_empty), 1);
    pulse_clr();
    check("hd_clr_fault", 32'(echo_fault), 0);

    // Echo timeout after exactly 24 bit ticks.
    push_tx(8'h40); push_tx(8'h41);
    serve_tx();
    bit_ticks(23);
    check("to_fault_before", 32'(echo_fault), 0);
    check("to_state_before", 32'(state), 32'(WAIT_ECHO));
    bit_tick = 1'b1;
    @(negedge clk);
    bit_tick = 1'b0;
    check("to_fault_after", 32'(echo_fault), 1);
    check("to_state_after", 32'(state), 32'(IDLE));
    serve_tx();
    rx_byte(8'h41, 1'b0, 1'b0);
    check("to_next_fault_held", 32'(echo_fault), 1);
    pulse_clr();
    check("to_clr", 32'(echo_fault), 0);

    // Guard time after an external RX byte.
    rx_byte(8'h7E, 1'b0, 1'b1);
    push_tx(8'h01);
    repeat (4) @(negedge clk);
    check("gd_state", 32'(state), 32'(GUARD));
    check("gd_no_start0", 32'(core_tx_start), 0);
    bit_ticks(1);
    check("gd_no_start1", 32'(core_tx_start), 0);
    bit_tick = 1'b1;
    @(negedge clk);
    bit_tick = 1'b0;
    check("gd_no_start2", 32'(core_tx_start), 0);
    repeat (2) @(negedge clk);
    check("gd_start", 32'(core_tx_start), 1);
    serve_tx();
    rx_byte(8'h01, 1'b0, 1'b0);
    read_rx("gd_rx_7e");

    // RX overflow and error tag.
    for (int i = 0; i < 17; i++) rx_byte(8'(8'h80 + i), (i == 5), (i < 16));
    check("ov_level", 32'(rx_level), 16);
    check("ov_flag", 32'(rx_overflow), 1);
    pulse_clr();
    check("ov_clr", 32'(rx_overflow), 0);
    head = exp_rx_q.pop_front();
    check("ov_head", 32'({rx_data_err, rx_data}), 32'(head));
    core_rx_data = 8'hC5; core_rx_valid = 1'b1; rx_rd_en = 1'b1;
    @(negedge clk);
    core_rx_valid = 1'b0; rx_rd_en = 1'b0;
    exp_rx_q.push_back({1'b0, 8'hC5});
    check("ov_rdwr_level", 32'(rx_level), 16);
    check("ov_rdwr_flag", 32'(rx_overflow), 0);
    for (int i = 0; i < 16; i++) read_rx("ov_rx");
    check("ov_drained", 32'(rx_empty), 1);

    // Flush from GUARD with five queued; a same-cycle write is dropped.
    for (int i = 0; i < 5; i++) push_tx(8'(8'h60 + i));
    @(negedge clk);
    check("fl_state_guard", 32'(state), 32'(GUARD));
    check("fl_level5", 32'(tx_level), 5);
    tx_flush = 1'b1; tx_wr_en = 1'b1; tx_data = 8'h99;
    @(negedge clk);
    tx_flush = 1'b0; tx_wr_en = 1'b0;
    exp_tx_q.delete();
    check("fl_level0", 32'(tx_level), 0);
    @(negedge clk);
    check("fl_state_idle", 32'(state), 32'(IDLE));
    check("fl_busy", 32'(busy), 0);

    // Async reset while START is requesting.
    hd_en = 1'b0;
    repeat (2) @(negedge clk);
    push_tx(8'h5A);
    push_tx(8'h5B);
    waited = 0;
    while (core_tx_start !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("ar_start_seen", 32'(core_tx_start), 1);
    #2 rst = 1'b0;
    #1;
    check("ar_tx_start", 32'(core_tx_start), 0);
    check("ar_tx_data", 32'(core_tx_data), 0);
    check("ar_state", 32'(state), 32'(IDLE));
    check("ar_tx_level", 32'(tx_level), 0);
    check("ar_busy", 32'(busy), 0);
    exp_tx_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push_tx(8'h3C);
    serve_tx();
    check("ar_after_rx_empty", 32'(rx_empty), 1);

    check("end_tx_q_empty", 32'(exp_tx_q.size()), 0);
    check("end_rx_q_empty", 32'(exp_rx_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
